// File: rtl/lss_pkg.sv
// Shared definitions for the logic/shift sequencer.
// Op codes, FSM encoding and default widths.
package lss_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_SLL  = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_SRA  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/logic_shift_sequencer_logic_unit.sv
// Single-cycle bitwise unit.
// fn selects AND / OR / XOR / NOR.
module logic_unit
  import lss_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       fn,
  output logic [WIDTH-1:0] y
);

  // Bitwise function select
  always_comb begin
    y = '0;
    unique case (fn)
      OP_AND[1:0]: y = a & b;
      OP_OR[1:0]:  y = a | b;
      OP_XOR[1:0]: y = a ^ b;
      OP_NOR[1:0]: y = ~(a | b);
      default:     y = '0;
    endcase
  end

endmodule

// File: rtl/logic_shift_sequencer.sv
// Logic/shift controller: bitwise ops in one cycle,
// shifts iterated one bit per cycle.
module logic_shift_sequencer
  import lss_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  state_t state, state_nxt;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   acc_nxt;
  logic [SHAMT_W-1:0] cnt;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   lu_y;
  logic [WIDTH-1:0]   lu_res;
  logic [SHAMT_W-1:0] shamt;

  logic accept;
  logic is_rsvd;
  logic is_shift;
  logic one_cyc;
  logic long_sh;
  logic last;

  logic_unit #(
    .WIDTH(WIDTH)
  ) u_lu (
    .a  (a),
    .b  (b),
    .fn (op[1:0]),
    .y  (lu_y)
  );

  assign shamt    = b[SHAMT_W-1:0];
  assign accept   = (state == S_IDLE) && req_valid;
  assign is_rsvd  = (op == OP_RSVD);
  assign is_shift = op[2] && !is_rsvd;
  assign long_sh  = is_shift && (shamt != '0);
  assign one_cyc  = !long_sh;
  assign lu_res   = is_rsvd ? '0 : lu_y;
  assign last     = (cnt == SHAMT_W'(1));

  // One-bit shift step in the latched direction
  always_comb begin
    acc_nxt = acc;
    unique case (op_q)
      OP_SLL:  acc_nxt = {acc[WIDTH-2:0], 1'b0};
      OP_SRL:  acc_nxt = {1'b0, acc[WIDTH-1:1]};
      OP_SRA:  acc_nxt = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default: acc_nxt = acc;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (req_valid)
          state_nxt = one_cyc ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (last) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready = (state == S_IDLE);
    res_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  // Datapath: operand capture, shift iteration, result write
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      acc    <= '0;
      cnt    <= '0;
      op_q   <= OP_AND;
    end else if (accept) begin
      unique case (1'b1)
        !is_shift: result <= lu_res;
        is_shift && !long_sh: result <= a;
        long_sh: begin
          acc  <= a;
          cnt  <= shamt;
          op_q <= op;
        end
        default: result <= result;
      endcase
    end else if (state == S_SHIFT) begin
      acc <= acc_nxt;
      cnt <= cnt - SHAMT_W'(1);
      if (last) result <= acc_nxt;
    end
  end

endmodule
